// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pkg.sv
// Shared definitions for the pipelined N-input NAND/AND/NOR/OR reduction cell:
// mode encodings and the elaboration-time helpers that size the reduction tree.
package gf180mcu_fd_sc_mcu9t5v0__nandn_pkg;

    // MODE[1] selects the family (0 = AND, 1 = OR); MODE[0]=0 inverts the result.
    typedef enum logic [1:0] {
        MODE_NAND = 2'b00,
        MODE_AND  = 2'b01,
        MODE_NOR  = 2'b10,
        MODE_OR   = 2'b11
    } mode_e;

    // Fan-in of every tree node.
    localparam int FANIN = 4;

    // Number of nodes at a given tree level; level 0 is the raw input vector.
    function automatic int groups(input int width, input int level);
        int n;
        n = width;
        for (int i = 0; i < level; i++) begin
            n = (n + FANIN - 1) / FANIN;
        end
        return n;
    endfunction

    // Tree depth: ceil(log4(width)), never less than one registered level.
    function automatic int clog4(input int width);
        int n;
        int lv;
        n  = width;
        lv = 0;
        for (int i = 0; i < 32; i++) begin
            if (n > 1) begin
                n  = (n + FANIN - 1) / FANIN;
                lv = lv + 1;
            end
        end
        if (lv < 1) begin
            lv = 1;
        end
        return lv;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_stage.sv
// One registered level of the reduction tree. Groups the incoming bits in
// fours, pads a short last group with the identity of the carried family,
// reduces each group and registers the result together with mode and valid.
module gf180mcu_fd_sc_mcu9t5v0__nandn_stage
    import gf180mcu_fd_sc_mcu9t5v0__nandn_pkg::*;
#(
    parameter  int IN_W  = 16,
    localparam int OUT_W = (IN_W + FANIN - 1) / FANIN
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic [1:0]       i_mode,
    input  logic [IN_W-1:0]  i_data,
    output logic [OUT_W-1:0] o_data,
    output logic [1:0]       o_mode,
    output logic             o_valid
);

    logic [FANIN*OUT_W-1:0] w_pad;
    logic [OUT_W-1:0]       w_red;
    logic [OUT_W-1:0]       r_data;
    logic [1:0]             r_mode;
    logic                   r_valid;

    // Pad with the family identity (1 for AND, 0 for OR) and reduce each group of four
    always_comb begin
        w_pad            = {(FANIN*OUT_W){~i_mode[1]}};
        w_pad[IN_W-1:0]  = i_data;
        w_red            = '0;
        for (int g = 0; g < OUT_W; g++) begin
            if (i_mode[1]) begin
                w_red[g] = |w_pad[g*FANIN +: FANIN];
            end else begin
                w_red[g] = &w_pad[g*FANIN +: FANIN];
            end
        end
    end

    // Level register: reset clears everything, EN=0 holds, otherwise load this cycle's item
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_mode  <= 2'b00;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_data  <= w_red;
            r_mode  <= i_mode;
            r_valid <= i_valid;
        end else begin
            r_data  <= r_data;
            r_mode  <= r_mode;
            r_valid <= r_valid;
        end
    end

    assign o_data  = r_data;
    assign o_mode  = r_mode;
    assign o_valid = r_valid;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe.sv
// Pipelined WIDTH-input NAND/AND/NOR/OR cell. A chain of LEVELS registered
// 4-input reduce stages carries data, mode and valid together so each item
// is evaluated with its own MODE; the final inversion is applied to the last
// level register. ZN is forced low whenever OUT_VALID is low, so the reset
// and bubble state of ZN is 0.
module gf180mcu_fd_sc_mcu9t5v0__nandn_pipe
    import gf180mcu_fd_sc_mcu9t5v0__nandn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       MODE,
    output logic             ZN,
    output logic             OUT_VALID,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int LEVELS = clog4(WIDTH);

    logic       w_last_data;
    logic [1:0] w_last_mode;
    logic       w_last_valid;
    logic       w_unused_s;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int IN_W  = groups(WIDTH, k - 1);
        localparam int OUT_W = groups(WIDTH, k);

        logic [IN_W-1:0]  w_in_data;
        logic [1:0]       w_in_mode;
        logic             w_in_valid;
        logic [OUT_W-1:0] w_out_data;
        logic [1:0]       w_out_mode;
        logic             w_out_valid;

        if (k == 1) begin : g_first
            assign w_in_data  = A;
            assign w_in_mode  = MODE;
            assign w_in_valid = IN_VALID;
        end else begin : g_next
            assign w_in_data  = g_lvl[k-1].w_out_data;
            assign w_in_mode  = g_lvl[k-1].w_out_mode;
            assign w_in_valid = g_lvl[k-1].w_out_valid;
        end

        gf180mcu_fd_sc_mcu9t5v0__nandn_stage #(
            .IN_W (IN_W)
        ) u_stage (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_en    (EN),
            .i_valid (w_in_valid),
            .i_mode  (w_in_mode),
            .i_data  (w_in_data),
            .o_data  (w_out_data),
            .o_mode  (w_out_mode),
            .o_valid (w_out_valid)
        );
    end

    assign w_last_data  = g_lvl[LEVELS].w_out_data[0];
    assign w_last_mode  = g_lvl[LEVELS].w_out_mode;
    assign w_last_valid = g_lvl[LEVELS].w_out_valid;

    // Supplies and the family bit are not needed after the last level
    assign w_unused_s = VDD ^ VSS ^ w_last_mode[1];

    // Final inversion for NAND/NOR, qualified by the last level's valid bit
    always_comb begin
        OUT_VALID = w_last_valid;
        ZN        = w_last_valid & (w_last_data ^ ~w_last_mode[0]);
    end

`ifndef FUNCTIONAL
    specify
        (CLK => ZN)        = (1.0, 1.0);
        (CLK => OUT_VALID) = (1.0, 1.0);
        $setup(A,        posedge CLK, 1.0);
        $hold (posedge CLK, A,        1.0);
        $setup(MODE,     posedge CLK, 1.0);
        $hold (posedge CLK, MODE,     1.0);
        $setup(IN_VALID, posedge CLK, 1.0);
        $hold (posedge CLK, IN_VALID, 1.0);
        $setup(EN,       posedge CLK, 1.0);
        $hold (posedge CLK, EN,       1.0);
        $setup(RST,      posedge CLK, 1.0);
        $hold (posedge CLK, RST,      1.0);
    endspecify
`endif

endmodule
